reg_bank_acc: RTL and testbench
===============================

Name: reg_bank_acc

Overview:
- Parametrised multi-lane register bank; generalises the single 21-bit load register to LANES independent WIDTH-bit registers.
- Per-cycle operations: load, signed accumulate with saturation, and lane-to-lane shift.
- Drain FSM streams all lanes out over a valid/ready port.
- Sits between the MAC datapath and the activation/output stage of the neural-network pipeline; holds partial sums per neuron.

Parameters:
- WIDTH, 21, bit width of each lane (signed two's complement).
- LANES, 4, number of lanes (>=2).
- SELW, $clog2(LANES), lane select width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  execute op this cycle (ignored while busy).
- op  input  2  00 clear-lane, 01 load, 10 accumulate, 11 shift.
- sel  input  SELW  target lane for clear/load/accumulate.
- din  input  WIDTH  operand data.
- drain  input  1  pulse: start streaming lanes 0..LANES-1.
- lanes_q  output  LANES*WIDTH  all lane values; lane i at [i*WIDTH +: WIDTH].
- ovf  output  LANES  sticky per-lane saturation flag.
- busy  output  1  high while in DRAIN.
- out_valid  output  1  drain beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  WIDTH  current drained lane value.
- out_last  output  1  high with final beat (lane LANES-1).

Behaviour:
- Reset: all lanes 0, ovf 0, FSM IDLE, busy 0, out_valid 0, out_last 0, out_data 0, drain index 0. Reset overrides everything, including mid-drain.
- Ops take effect only when en=1 and state=IDLE. Result is visible on lanes_q the cycle after the edge (1-cycle latency).
- op 00 clear: lane[sel] <= 0; ovf[sel] <= 0.
- op 01 load: lane[sel] <= din; ovf[sel] <= 0.
- op 10 accumulate: lane[sel] <= sat(lane[sel] + din).
  - Sum computed at WIDTH+1 bits.
  - Overflow clamps to 2^(WIDTH-1)-1; underflow clamps to -2^(WIDTH-1).
  - Any clamp sets ovf[sel]; ovf is sticky.
- op 11 shift: lane[0] <= din; lane[i] <= lane[i-1] for i>0; ovf shifts identically with ovf[0] <= 0. sel is ignored. Old lane[LANES-1] is discarded.
- sel >= LANES (non-power-of-two LANES): op is a no-op.
- FSM IDLE:
  - drain=1 goes to DRAIN with index 0. busy, out_valid and the lane-0 out_data appear the next cycle.
  - drain and en in the same cycle: the op executes first, then the drain snapshot reflects the updated lanes.
- FSM DRAIN:
  - out_valid=1; out_data=lane[index]; out_last=(index==LANES-1).
  - Lanes are frozen and en is ignored.
  - Beat accepted when out_valid&out_ready; the index increments on acceptance.
  - When the last beat is accepted, return to IDLE: out_valid, out_last and busy drop the next cycle.
  - out_ready=0 holds out_data/out_last stable (no beat loss).
  - drain asserted while already in DRAIN is ignored.
- Lane values are not modified by draining.

Optional Feature:
- Macro: REG_BANK_ACC_SAT_EN.
- Defined: saturating accumulate and ovf flags as above.
- Undefined: accumulate wraps modulo 2^WIDTH; ovf output tied to 0; all other behaviour unchanged.

Test Plan:
- Reset then load (sel=2, din=21'h00ABC) -> next cycle lane2=0x00ABC, other lanes 0, ovf=0.
- Saturation (macro defined): load lane1=1048570, accumulate din=100 -> lane1=1048575, ovf[1]=1. Then load 5 -> lane1=5, ovf[1]=0. Without the macro, the same stimulus gives lane1=-1048482 (wrapped), ovf=0.
- Underflow: load lane0=-1048570, accumulate din=-50 -> lane0=-1048576, ovf[0]=1.
- Shift: lanes {0:1,1:2,2:3,3:4}, shift din=9 -> lanes {0:9,1:1,2:2,3:3}; ovf shifts with the data.
- Drain with backpressure: lanes {10,20,30,40}, pulse drain, out_ready toggling 1,0,1,1,0,1 -> beats 10,20,30,40 in order; out_data stable while ready=0; out_last only with 40; en load during busy has no effect; busy drops after the 40 beat.
- Reset mid-drain after the second beat -> next cycle out_valid=0, busy=0, all lanes 0, ovf=0; a subsequent drain starts from lane 0.

Source files
------------

// File: rtl/reg_bank_acc.sv
// reg_bank_acc: LANES independent signed WIDTH-bit partial-sum registers with
// load, clear, accumulate and lane-to-lane shift. A drain FSM streams every
// lane out over a valid/ready port.
//
// Build option: define REG_BANK_ACC_SAT_EN for a saturating accumulate with
// sticky per-lane ovf flags. Without it, the accumulate wraps modulo 2^WIDTH
// and ovf stays 0.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   en, op, sel   execute op (00 clear, 01 load, 10 accumulate, 11 shift)
//                 on lane sel. Ignored while busy.
//   din           operand data
//   drain         pulse to stream lanes 0..LANES-1 out
//   lanes_q       all lanes; lane i is at [i*WIDTH +: WIDTH]
//   ovf           sticky per-lane saturation flags
//   busy          high while draining
//   out_valid/out_ready/out_data/out_last  drain stream; last marks lane LANES-1
module reg_bank_acc #(
  parameter int WIDTH = 21,
  parameter int LANES = 4,
  parameter int SELW  = $clog2(LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               op,
  input  logic [SELW-1:0]          sel,
  input  logic [WIDTH-1:0]         din,
  input  logic                     drain,
  output logic [LANES*WIDTH-1:0]   lanes_q,
  output logic [LANES-1:0]         ovf,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} state_t;

  localparam logic [SELW-1:0] LAST_IDX = SELW'(LANES - 1);

`ifdef REG_BANK_ACC_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Returns {clamped, result}. The sum is formed one bit wider so that a
  // disagreement between the two top bits flags signed overflow; the top bit
  // then gives the true sign and picks which rail to clamp to.
  function automatic logic [WIDTH:0] acc_fn(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] res;
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
`ifdef REG_BANK_ACC_SAT_EN
    if (sum[WIDTH] != sum[WIDTH-1]) begin
      res = {1'b1, (sum[WIDTH] ? SAT_MIN : SAT_MAX)};
    end else begin
      res = {1'b0, sum[WIDTH-1:0]};
    end
`else
    res = {1'b0, sum[WIDTH-1:0]};
`endif
    return res;
  endfunction

  logic [WIDTH-1:0] lane_r      [LANES];
  logic [WIDTH-1:0] lane_next_s [LANES];
  logic [LANES-1:0] ovf_r, ovf_next_s;
  state_t           state_r, state_next_s;
  logic [SELW-1:0]  idx_r, idx_next_s;
  logic             busy_r, out_valid_r, out_last_r;
  logic [WIDTH-1:0] out_data_r, out_data_next_s;
  logic             sel_ok_s;
  logic [WIDTH-1:0] sel_lane_s;
  logic [WIDTH:0]   acc_res_s;

  // sel values past the last lane (non-power-of-two LANES) turn ops into no-ops.
  assign sel_ok_s   = ({{(32-SELW){1'b0}}, sel} < 32'(LANES));
  assign sel_lane_s = sel_ok_s ? lane_r[sel] : {WIDTH{1'b0}};
  assign acc_res_s  = acc_fn(sel_lane_s, din);

  // Next lane and flag values from the op; lanes are frozen outside IDLE.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_next_s[i] = lane_r[i];
    end
    ovf_next_s = ovf_r;
    if (en && (state_r == ST_IDLE)) begin
      case (op)
        2'b00: begin
          if (sel_ok_s) begin
            lane_next_s[sel] = {WIDTH{1'b0}};
            ovf_next_s[sel]  = 1'b0;
          end else begin
            ovf_next_s = ovf_r;
          end
        end
        2'b01: begin
          if (sel_ok_s) begin
            lane_next_s[sel] = din;
            ovf_next_s[sel]  = 1'b0;
          end else begin
            ovf_next_s = ovf_r;
          end
        end
        2'b10: begin
          if (sel_ok_s) begin
            lane_next_s[sel] = acc_res_s[WIDTH-1:0];
            ovf_next_s[sel]  = ovf_r[sel] | acc_res_s[WIDTH];
          end else begin
            ovf_next_s = ovf_r;
          end
        end
        2'b11: begin
          lane_next_s[0] = din;
          for (int i = 1; i < LANES; i++) begin
            lane_next_s[i] = lane_r[i-1];
          end
          ovf_next_s = {ovf_r[LANES-2:0], 1'b0};
        end
        default: begin
          ovf_next_s = ovf_r;
        end
      endcase
    end else begin
      ovf_next_s = ovf_r;
    end
  end

  // Drain FSM next state plus the registered stream outputs. out_data reads
  // the post-op lane values so a drain issued with an op sees the update.
  always_comb begin
    state_next_s    = state_r;
    idx_next_s      = idx_r;
    out_data_next_s = {WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        idx_next_s = {SELW{1'b0}};
        if (drain) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (out_valid_r && out_ready) begin
          if (idx_r == LAST_IDX) begin
            state_next_s = ST_IDLE;
            idx_next_s   = {SELW{1'b0}};
          end else begin
            idx_next_s = idx_r + SELW'(1);
          end
        end else begin
          idx_next_s = idx_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        idx_next_s   = {SELW{1'b0}};
      end
    endcase
    if (state_next_s == ST_DRAIN) begin
      out_data_next_s = lane_next_s[idx_next_s];
    end else begin
      out_data_next_s = {WIDTH{1'b0}};
    end
  end

  // State, lane and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= {WIDTH{1'b0}};
      end
      ovf_r       <= {LANES{1'b0}};
      state_r     <= ST_IDLE;
      idx_r       <= {SELW{1'b0}};
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= lane_next_s[i];
      end
      ovf_r       <= ovf_next_s;
      state_r     <= state_next_s;
      idx_r       <= idx_next_s;
      busy_r      <= (state_next_s == ST_DRAIN);
      out_valid_r <= (state_next_s == ST_DRAIN);
      out_last_r  <= (state_next_s == ST_DRAIN) && (idx_next_s == LAST_IDX);
      out_data_r  <= out_data_next_s;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
    assign lanes_q[gi*WIDTH +: WIDTH] = lane_r[gi];
  end

  assign ovf       = ovf_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_reg_bank_acc.sv
module tb_reg_bank_acc;
  localparam int W = 21;
  localparam int L = 4;
`ifdef REG_BANK_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, en, drain, out_ready;
  logic [1:0]     op, sel;
  logic [W-1:0]   din;
  logic [L*W-1:0] lanes_q;
  logic [L-1:0]   ovf;
  logic           busy, out_valid, out_last;
  logic [W-1:0]   out_data;

  int n_vec = 0;
  int n_err = 0;

  reg_bank_acc #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .sel(sel), .din(din),
    .drain(drain), .lanes_q(lanes_q), .ovf(ovf), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [1:0]   op;
    logic [1:0]   sel;
    logic [W-1:0] din;
    logic [W-1:0] e0, e1, e2, e3;
    logic [L-1:0] eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [L*W-1:0] pack4(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic add(input logic e, input logic [1:0] o, input logic [1:0] s,
                     input logic [W-1:0] d, input logic [W-1:0] l0, l1, l2, l3,
                     input logic [L-1:0] ov);
    vec_t v;
    v.en = e; v.op = o; v.sel = s; v.din = d;
    v.e0 = l0; v.e1 = l1; v.e2 = l2; v.e3 = l3; v.eovf = ov;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_beat [4];
  bit           pat      [6];
  int           idx;

  initial begin
    rst = 1'b1; en = 1'b0; op = 2'b00; sel = 2'b00; din = '0;
    drain = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    chk("reset lanes", 128'(lanes_q), 128'(0));
    chk("reset ovf", 128'(ovf), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset out_last", 128'(out_last), 128'(0));
    chk("reset out_data", 128'(out_data), 128'(0));
    rst = 1'b0;

    // en op sel din | expected lanes 0..3 | ovf
    add(1'b1, 2'b01, 2'd2, 21'h00ABC, 21'h0, 21'h0, 21'h00ABC, 21'h0, 4'b0000);
    add(1'b0, 2'b01, 2'd0, 21'h00005, 21'h0, 21'h0, 21'h00ABC, 21'h0, 4'b0000);
    add(1'b1, 2'b01, 2'd1, 21'h0FFFFA, 21'h0, 21'h0FFFFA, 21'h00ABC, 21'h0, 4'b0000);
    add(1'b1, 2'b10, 2'd1, 21'h00064, 21'h0, SAT ? 21'h0FFFFF : 21'h10005E, 21'h00ABC, 21'h0,
        SAT ? 4'b0010 : 4'b0000);
    add(1'b1, 2'b10, 2'd1, 21'h00001, 21'h0, SAT ? 21'h0FFFFF : 21'h10005F, 21'h00ABC, 21'h0,
        SAT ? 4'b0010 : 4'b0000);
    add(1'b1, 2'b01, 2'd1, 21'h00005, 21'h0, 21'h5, 21'h00ABC, 21'h0, 4'b0000);
    add(1'b1, 2'b01, 2'd0, 21'h100006, 21'h100006, 21'h5, 21'h00ABC, 21'h0, 4'b0000);
    add(1'b1, 2'b10, 2'd0, 21'h1FFFCE, SAT ? 21'h100000 : 21'h0FFFD4, 21'h5, 21'h00ABC, 21'h0,
        SAT ? 4'b0001 : 4'b0000);
    add(1'b1, 2'b10, 2'd2, 21'h00010, SAT ? 21'h100000 : 21'h0FFFD4, 21'h5, 21'h00ACC, 21'h0,
        SAT ? 4'b0001 : 4'b0000);
    add(1'b1, 2'b11, 2'd3, 21'h00009, 21'h9, SAT ? 21'h100000 : 21'h0FFFD4, 21'h5, 21'h00ACC,
        SAT ? 4'b0010 : 4'b0000);
    add(1'b1, 2'b00, 2'd1, 21'h12345, 21'h9, 21'h0, 21'h5, 21'h00ACC, 4'b0000);
    add(1'b1, 2'b01, 2'd0, 21'h1, 21'h1, 21'h0, 21'h5, 21'h00ACC, 4'b0000);
    add(1'b1, 2'b01, 2'd1, 21'h2, 21'h1, 21'h2, 21'h5, 21'h00ACC, 4'b0000);
    add(1'b1, 2'b01, 2'd2, 21'h3, 21'h1, 21'h2, 21'h3, 21'h00ACC, 4'b0000);
    add(1'b1, 2'b01, 2'd3, 21'h4, 21'h1, 21'h2, 21'h3, 21'h4, 4'b0000);
    add(1'b1, 2'b11, 2'd0, 21'h9, 21'h9, 21'h1, 21'h2, 21'h3, 4'b0000);
    add(1'b1, 2'b10, 2'd3, 21'h1FFFFF, 21'h9, 21'h1, 21'h2, 21'h2, 4'b0000);
    add(1'b1, 2'b01, 2'd0, 21'd10, 21'd10, 21'h1, 21'h2, 21'h2, 4'b0000);
    add(1'b1, 2'b01, 2'd1, 21'd20, 21'd10, 21'd20, 21'h2, 21'h2, 4'b0000);
    add(1'b1, 2'b01, 2'd2, 21'd30, 21'd10, 21'd20, 21'd30, 21'h2, 4'b0000);
    add(1'b1, 2'b01, 2'd3, 21'd40, 21'd10, 21'd20, 21'd30, 21'd40, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; op = tbl[i].op; sel = tbl[i].sel; din = tbl[i].din;
      cyc();
      chk($sformatf("vec%0d lanes", i), 128'(lanes_q),
          128'(pack4(tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3)));
      chk($sformatf("vec%0d ovf", i), 128'(ovf), 128'(tbl[i].eovf));
    end
    en = 1'b0;

    // Drain with backpressure; loads and a second drain while busy are ignored.
    exp_beat = '{21'd10, 21'd20, 21'd30, 21'd40};
    pat      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    chk("drain busy", 128'(busy), 128'(1));
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("beat%0d valid", k), 128'(out_valid), 128'(1));
      chk($sformatf("beat%0d data", k), 128'(out_data), 128'(exp_beat[idx]));
      chk($sformatf("beat%0d last", k), 128'(out_last), 128'(idx == 3));
      out_ready = pat[k];
      en = 1'b1; op = 2'b01; sel = 2'd0; din = 21'h777;
      drain = (k == 2);
      cyc();
      if (pat[k]) idx++;
    end
    en = 1'b0; drain = 1'b0; out_ready = 1'b0;
    chk("drain beats", 128'(idx), 128'(4));
    chk("drain end busy", 128'(busy), 128'(0));
    chk("drain end valid", 128'(out_valid), 128'(0));
    chk("drain end last", 128'(out_last), 128'(0));
    chk("drain lanes kept", 128'(lanes_q), 128'(pack4(21'd10, 21'd20, 21'd30, 21'd40)));

    // Reset in the middle of a drain.
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    out_ready = 1'b1;
    cyc(); cyc();
    chk("mid drain data", 128'(out_data), 128'(30));
    out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst mid valid", 128'(out_valid), 128'(0));
    chk("rst mid busy", 128'(busy), 128'(0));
    chk("rst mid lanes", 128'(lanes_q), 128'(0));
    chk("rst mid ovf", 128'(ovf), 128'(0));
    chk("rst mid last", 128'(out_last), 128'(0));

    // Fresh drain starts at lane 0 and sees an op issued in the same cycle.
    en = 1'b1; op = 2'b01; sel = 2'd1; din = 21'h66;
    cyc();
    sel = 2'd0; din = 21'h99; drain = 1'b1;
    cyc();
    en = 1'b0; drain = 1'b0;
    chk("redrain valid", 128'(out_valid), 128'(1));
    chk("redrain lane0", 128'(out_data), 128'(21'h99));
    out_ready = 1'b1;
    cyc();
    chk("redrain lane1", 128'(out_data), 128'(21'h66));
    cyc(); cyc();
    chk("redrain last", 128'(out_last), 128'(1));
    chk("redrain lane3", 128'(out_data), 128'(0));
    cyc();
    out_ready = 1'b0;
    chk("redrain done", 128'(busy), 128'(0));
    chk("redrain lanes", 128'(lanes_q), 128'(pack4(21'h99, 21'h66, 21'h0, 21'h0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
